// File: rtl/flash_arbiter_if.sv
// -----------------------------------------------------------------------------
// flash_arbiter_if
//
// Purpose: bundles every signal between the flash arbiter and its environment
// (the two requesting clients and the register-mapped SPI flash controller).
// The arbiter uses the "slave" modport. The environment (clients plus
// controller, or a testbench standing in for them) uses the "master" modport.
//
// Client handshake (one per port, n = 0/1):
//   reqn is raised with wen/addrn/wdatan stable and held until ackn. ackn is a
//   single-cycle pulse, and errn/rdatan are valid in that same cycle. The
//   client drops reqn in the cycle after ackn, so the arbiter can grant again
//   no earlier than the second cycle after the ack.
//
// Signal summary:
//   req0/req1         client -> arb   request, held until ack
//   we0/we1           client -> arb   1 = write, 0 = read
//   addr0/addr1 [23:0] client -> arb  flash word address
//   wdata0/wdata1[31:0] client -> arb write data
//   ack0/ack1         arb -> client   one-cycle completion pulse
//   err0/err1         arb -> client   valid with ack: timeout or range error
//   rdata0/rdata1[31:0] arb -> client read data, held until the next ack
//   busy              arb -> env      high whenever the arbiter is not idle
//   grant[1:0]        arb -> env      one-hot owner of the current op
//   fc_ren/fc_wen     arb -> ctrl     register read / write strobes
//   fc_address[7:0]   arb -> ctrl     register index
//   fc_data_in[31:0]  arb -> ctrl     register write data
//   fc_data_out[31:0] ctrl -> arb     register read data, one cycle after fc_ren
//   dbg_state[3:0]    arb -> env      current FSM state, for observation
// -----------------------------------------------------------------------------
interface flash_arbiter_if;
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [23:0] addr0;
  logic [23:0] addr1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic        ack0;
  logic        ack1;
  logic        err0;
  logic        err1;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  logic        busy;
  logic [1:0]  grant;
  logic        fc_ren;
  logic        fc_wen;
  logic [7:0]  fc_address;
  logic [31:0] fc_data_in;
  logic [31:0] fc_data_out;
  logic [3:0]  dbg_state;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, fc_data_out,
    output ack0, ack1, err0, err1, rdata0, rdata1, busy, grant,
           fc_ren, fc_wen, fc_address, fc_data_in, dbg_state
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, fc_data_out,
    input  ack0, ack1, err0, err1, rdata0, rdata1, busy, grant,
           fc_ren, fc_wen, fc_address, fc_data_in, dbg_state
  );
endinterface

// File: rtl/flash_arbiter.sv
// -----------------------------------------------------------------------------
// flash_arbiter
//
// Purpose: shares one register-mapped SPI flash controller between two
// clients. Each single-word client request is turned into the controller's
// register sequence: program ADDRESS (and DATAIN for writes), arm
// READEN/WRITEEN, poll the arm register until it auto-clears, and for reads
// fetch DATAOUT. Ties are broken round-robin. A poll budget aborts stuck ops,
// and addresses above ADDR_LIMIT are rejected without any bus traffic.
//
// Ports:
//   clk      clock
//   reset_n  asynchronous, active-low reset (returns to IDLE, no ack issued)
//   bus      flash_arbiter_if.slave: client request/ack ports, status,
//            controller register bus and FSM debug state
//
// Parameters:
//   POLL_TIMEOUT  poll iterations allowed before an op is aborted with err=1
//   ADDR_LIMIT    highest legal word address (inclusive)
//
// Whenever no strobe is active, fc_address and fc_data_in sit at zero so the
// bus is quiet and easy to read in traces.
// -----------------------------------------------------------------------------
module flash_arbiter #(
  parameter int unsigned POLL_TIMEOUT = 65535,
  parameter logic [23:0] ADDR_LIMIT   = 24'h0FFFFF
) (
  input logic            clk,
  input logic            reset_n,
  flash_arbiter_if.slave bus
);

  // Poll counter only needs to reach POLL_TIMEOUT-1.
  localparam int unsigned   CW        = (POLL_TIMEOUT > 1) ? $clog2(POLL_TIMEOUT) : 1;
  localparam logic [CW-1:0] POLL_LAST = CW'(POLL_TIMEOUT - 1);

  // Controller register map.
  localparam logic [7:0] REG_READEN  = 8'h01;
  localparam logic [7:0] REG_WRITEEN = 8'h02;
  localparam logic [7:0] REG_ADDRESS = 8'h04;
  localparam logic [7:0] REG_DATAIN  = 8'h08;
  localparam logic [7:0] REG_DATAOUT = 8'h0C;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_W_ADDR   = 4'd1,
    S_W_DATA   = 4'd2,
    S_W_ARM    = 4'd3,
    S_POLL_RD  = 4'd4,
    S_POLL_CHK = 4'd5,
    S_RD_OUT   = 4'd6,
    S_RD_CAP   = 4'd7,
    S_ABORT    = 4'd8,
    S_DONE     = 4'd9
  } state_t;

  state_t state;
  state_t state_nxt;

  // Latched operation context.
  logic          last_grant;  // port that owned the previous op
  logic [1:0]    grant_q;
  logic          op_we;
  logic [23:0]   op_addr;
  logic [31:0]   op_wdata;
  logic          op_err;
  logic [CW-1:0] poll_cnt;
  logic [31:0]   rdata0_q;
  logic [31:0]   rdata1_q;

  // ---------------------------------------------------------------------------
  // Arbitration: with both requests high the port that did not own the last
  // op wins; otherwise whichever single port is requesting.
  // ---------------------------------------------------------------------------
  logic        any_req;
  logic        pick;        // 0 = port 0, 1 = port 1
  logic        sel_we;
  logic [23:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_bad;

  always_comb begin
    any_req   = bus.req0 | bus.req1;
    pick      = (bus.req0 & bus.req1) ? ~last_grant : bus.req1;
    sel_we    = pick ? bus.we1    : bus.we0;
    sel_addr  = pick ? bus.addr1  : bus.addr0;
    sel_wdata = pick ? bus.wdata1 : bus.wdata0;
    sel_bad   = (sel_addr > ADDR_LIMIT);
  end

  logic       arm_done;
  logic [7:0] arm_reg;

  always_comb begin
    arm_done = (bus.fc_data_out == 32'h0);
    arm_reg  = op_we ? REG_WRITEEN : REG_READEN;
  end

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          // Out-of-range requests skip the bus entirely.
          state_nxt = sel_bad ? S_DONE : S_W_ADDR;
        end
      end
      S_W_ADDR:  state_nxt = op_we ? S_W_DATA : S_W_ARM;
      S_W_DATA:  state_nxt = S_W_ARM;
      S_W_ARM:   state_nxt = S_POLL_RD;
      S_POLL_RD: state_nxt = S_POLL_CHK;
      S_POLL_CHK: begin
        if (arm_done) begin
          state_nxt = op_we ? S_DONE : S_RD_OUT;
        end else if (poll_cnt == POLL_LAST) begin
          state_nxt = S_ABORT;
        end else begin
          state_nxt = S_POLL_RD;
        end
      end
      S_RD_OUT:  state_nxt = S_RD_CAP;
      S_RD_CAP:  state_nxt = S_DONE;
      S_ABORT:   state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operation context and read-data registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;  // so port 0 wins the first tie
      grant_q    <= 2'b00;
      op_we      <= 1'b0;
      op_addr    <= 24'h0;
      op_wdata   <= 32'h0;
      op_err     <= 1'b0;
      poll_cnt   <= '0;
      rdata0_q   <= 32'h0;
      rdata1_q   <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            last_grant <= pick;
            grant_q    <= pick ? 2'b10 : 2'b01;
            op_we      <= sel_we;
            op_addr    <= sel_addr;
            op_wdata   <= sel_wdata;
            op_err     <= sel_bad;
            poll_cnt   <= '0;
          end
        end
        S_POLL_CHK: begin
          if (!arm_done && (poll_cnt != POLL_LAST)) begin
            poll_cnt <= poll_cnt + CW'(1);
          end
        end
        S_RD_CAP: begin
          if (grant_q[1]) begin
            rdata1_q <= bus.fc_data_out;
          end else begin
            rdata0_q <= bus.fc_data_out;
          end
        end
        S_ABORT: op_err  <= 1'b1;
        S_DONE:  grant_q <= 2'b00;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: outputs decoded from state (never more than one strobe)
  // ---------------------------------------------------------------------------
  logic        fc_ren;
  logic        fc_wen;
  logic [7:0]  fc_address;
  logic [31:0] fc_data_in;
  logic        done;

  always_comb begin
    fc_ren     = 1'b0;
    fc_wen     = 1'b0;
    fc_address = 8'h00;
    fc_data_in = 32'h0;
    done       = (state == S_DONE);
    case (state)
      S_W_ADDR: begin
        fc_wen     = 1'b1;
        fc_address = REG_ADDRESS;
        fc_data_in = {8'h00, op_addr};
      end
      S_W_DATA: begin
        fc_wen     = 1'b1;
        fc_address = REG_DATAIN;
        fc_data_in = op_wdata;
      end
      S_W_ARM: begin
        fc_wen     = 1'b1;
        fc_address = arm_reg;
        fc_data_in = 32'h1;
      end
      S_POLL_RD: begin
        fc_ren     = 1'b1;
        fc_address = arm_reg;
      end
      S_RD_OUT: begin
        fc_ren     = 1'b1;
        fc_address = REG_DATAOUT;
      end
      S_ABORT: begin
        // Disarm so the controller does not finish the op behind our back.
        fc_wen     = 1'b1;
        fc_address = arm_reg;
        fc_data_in = 32'h0;
      end
      default: ;
    endcase
  end

  assign bus.fc_ren     = fc_ren;
  assign bus.fc_wen     = fc_wen;
  assign bus.fc_address = fc_address;
  assign bus.fc_data_in = fc_data_in;
  assign bus.ack0       = done & grant_q[0];
  assign bus.ack1       = done & grant_q[1];
  assign bus.err0       = done & grant_q[0] & op_err;
  assign bus.err1       = done & grant_q[1] & op_err;
  assign bus.rdata0     = rdata0_q;
  assign bus.rdata1     = rdata1_q;
  assign bus.busy       = (state != S_IDLE);
  assign bus.grant      = grant_q;
  assign bus.dbg_state  = state;

endmodule
